spi_mosi_rx: RTL and testbench

Slave-side receiver sitting directly downstream of spi_mosi. It consumes the serial MOSI bit stream and spi_cs framing, and deserialises bits into DATA_W-bit words. Completed words go into a small first-word-fall-through FIFO, which is drained by a valid/ready consumer in the same spi_clk domain. Framing and overflow errors are reported through sticky flags.

---
 rtl/spi_mosi_rx.sv | 117 +++++++++++
 tb/tb_spi_mosi_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mosi_rx.sv
// SPI slave receive path: deserialises MOSI into DATA_W-bit words, buffers them in a FWFT FIFO,
// and reports framing/overflow errors as sticky flags. Define SPI_RX_LSB_FIRST_EN for LSB-first assembly.
module spi_mosi_rx #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              spi_clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_mosi_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [CNT_W-1:0]  rx_count,
  output logic              rx_overflow,
  output logic              rx_frame_err,
  input  logic              err_clr,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] next_sreg;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              sample;
  logic              word_done;
  logic              frame_abort;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              drop;

  // NOTE: always_comb with a full assignment on every path; nothing here can hold a value, so no latch.
  always_comb begin
`ifdef SPI_RX_LSB_FIRST_EN
    next_sreg = {spi_mosi_in, sreg[DATA_W-1:1]};
`else
    next_sreg = {sreg[DATA_W-2:0], spi_mosi_in};
`endif
  end

  // Every edge with chip select low samples a bit, including the IDLE->SHIFT edge.
  assign sample      = !spi_cs;
  assign word_done   = sample && (bit_cnt == BW'(DATA_W - 1));
  assign frame_abort = spi_cs && (state == SHIFT) && (bit_cnt != '0);

  assign rx_valid = (rx_count != '0);
  assign pop      = rx_valid && rx_ready;
  assign full     = (rx_count == CNT_W'(DEPTH));
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push_ok  = word_done && (!full || pop);
  assign drop     = word_done && full && !pop;
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      bit_cnt <= '0;
      sreg    <= '0;
    end else begin
      case (state)
        IDLE: if (!spi_cs) begin
          state <= SHIFT;
          busy  <= 1'b1;
        end
        SHIFT: if (spi_cs) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (sample) begin
        sreg    <= next_sreg;
        bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
      end else begin
        bit_cnt <= '0;
      end
    end
  end

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rx_count     <= '0;
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   rx_count <= rx_count + CNT_W'(1);
        2'b01:   rx_count <= rx_count - CNT_W'(1);
        default: rx_count <= rx_count;
      endcase
      // A new error on the clearing edge wins over the clear.
      rx_overflow  <= (rx_overflow  && !err_clr) || drop;
      rx_frame_err <= (rx_frame_err && !err_clr) || frame_abort;
    end
  end

  // NOTE: storage is not reset; rx_data is masked while empty, so stale entries are never visible.
  always_ff @(posedge spi_clk) begin
    if (push_ok) mem[wr_ptr] <= next_sreg;
  end

endmodule

// File: tb/tb_spi_mosi_rx.sv
// Self-checking bench for spi_mosi_rx: directed scenarios plus random traffic against a queue-based model.
module tb_spi_mosi_rx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              spi_clk = 1'b0;
  logic              reset = 1'b1;
  logic              spi_cs = 1'b1;
  logic              spi_mosi_in = 1'b0;
  logic              rx_ready = 1'b0;
  logic              err_clr = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [CNT_W-1:0]  rx_count;
  logic              rx_overflow;
  logic              rx_frame_err;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word queue, collected-bit count, accumulator, flags.
  logic [DATA_W-1:0] m_q [$];
  int                m_nb = 0;
  int unsigned       m_acc = 0;
  bit                m_busy = 0;
  bit                m_ovf = 0;
  bit                m_ferr = 0;

  spi_mosi_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .spi_clk(spi_clk), .reset(reset), .spi_cs(spi_cs), .spi_mosi_in(spi_mosi_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err), .err_clr(err_clr), .busy(busy)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_nb = 0; m_acc = 0; m_busy = 0; m_ovf = 0; m_ferr = 0;
  endtask

  // Applies the inputs currently driven to the model, as of the coming edge.
  task automatic model_edge();
    bit                pop = (m_q.size() != 0) && rx_ready;
    int                sz = m_q.size();
    bit                push = 0;
    bit                ovf_e = 0;
    bit                fe_e = 0;
    logic [DATA_W-1:0] w = '0;
    if (!spi_cs) begin
      m_busy = 1;
`ifdef SPI_RX_LSB_FIRST_EN
      m_acc = m_acc + (int'(spi_mosi_in) << m_nb);
`else
      m_acc = (m_acc * 2 + int'(spi_mosi_in)) % (1 << DATA_W);
`endif
      m_nb++;
      if (m_nb == DATA_W) begin
        push = 1; w = DATA_W'(m_acc); m_acc = 0; m_nb = 0;
      end
    end else if (m_busy) begin
      m_busy = 0;
      if (m_nb != 0) fe_e = 1;
      m_nb = 0; m_acc = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz == DEPTH && !pop) ovf_e = 1;
      else m_q.push_back(w);
    end
    if (err_clr) begin m_ovf = 0; m_ferr = 0; end
    if (ovf_e) m_ovf = 1;
    if (fe_e)  m_ferr = 1;
  endtask

  task automatic compare_all();
    check("busy", busy, m_busy);
    check("rx_valid", rx_valid, m_q.size() != 0);
    check("rx_count", rx_count, m_q.size());
    check("rx_overflow", rx_overflow, m_ovf);
    check("rx_frame_err", rx_frame_err, m_ferr);
    if (m_q.size() != 0) check("rx_data", rx_data, m_q[0]);
  endtask

  task automatic tick();
    model_edge();
    @(posedge spi_clk);
    #1;
    compare_all();
  endtask

  // i-th transmitted bit so that the assembled word equals w in either build.
  function automatic logic tx_bit(input logic [DATA_W-1:0] w, input int i);
`ifdef SPI_RX_LSB_FIRST_EN
    return w[i];
`else
    return w[DATA_W-1-i];
`endif
  endfunction

  task automatic send_word(input logic [DATA_W-1:0] w);
    spi_cs = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      spi_mosi_in = tx_bit(w, i);
      tick();
    end
  endtask

  task automatic idle(input int n);
    spi_cs = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain_expect(input logic [DATA_W-1:0] w);
    check("drain_head", rx_data, w);
    spi_cs   = 1'b1;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] got [$];
    int                max_cnt;

    // Reset state
    repeat (2) @(posedge spi_clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_count", rx_count, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {rx_overflow, rx_frame_err}, 0);
    reset = 1'b0;

    // 1. Single word from a raw bit sequence, then the bit-order-sensitive pattern
    pat = 8'b1010_0101;
    spi_cs = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin spi_mosi_in = pat[i]; tick(); end
    check("t1_valid", rx_valid, 1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_count", rx_count, 1);
    check("t1_busy", busy, 1);
    pat = 8'b1100_0000;
    for (int i = DATA_W - 1; i >= 0; i--) begin spi_mosi_in = pat[i]; tick(); end
    idle(1);
    drain_expect(8'hA5);
`ifdef SPI_RX_LSB_FIRST_EN
    drain_expect(8'h03);
`else
    drain_expect(8'hC0);
`endif

    // 2. Back-to-back words with a consumer always ready
    rx_ready = 1'b1;
    max_cnt  = 0;
    spi_cs   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (rx_valid) got.push_back(rx_data);
        spi_mosi_in = tx_bit(DATA_W'(k), i);
        tick();
        if (int'(rx_count) > max_cnt) max_cnt = int'(rx_count);
      end
    end
    spi_cs = 1'b1;
    if (rx_valid) got.push_back(rx_data);
    tick();
    rx_ready = 1'b0;
    check("t2_npops", got.size(), 3);
    for (int k = 0; k < got.size() && k < 3; k++) check("t2_order", got[k], k + 1);
    check("t2_maxcnt", max_cnt, 1);
    check("t2_errs", {rx_overflow, rx_frame_err}, 0);

    // 3. Overflow: fifth word dropped, order preserved, err_clr clears
    for (int k = 0; k < 5; k++) send_word(DATA_W'(8'h10 + k));
    check("t3_count", rx_count, DEPTH);
    check("t3_ovf", rx_overflow, 1);
    idle(1);
    for (int k = 0; k < 4; k++) drain_expect(DATA_W'(8'h10 + k));
    clear_errors();
    check("t3_ovf_clr", rx_overflow, 0);

    // 4. Full FIFO with push and pop on the same edge
    for (int k = 0; k < 4; k++) send_word(DATA_W'(8'h10 + k));
    for (int i = 0; i < DATA_W - 1; i++) begin spi_mosi_in = tx_bit(8'h14, i); tick(); end
    rx_ready = 1'b1;
    spi_mosi_in = tx_bit(8'h14, DATA_W - 1);
    tick();
    rx_ready = 1'b0;
    check("t4_count", rx_count, DEPTH);
    check("t4_ovf", rx_overflow, 0);
    check("t4_head", rx_data, 8'h11);
    idle(1);
    for (int k = 1; k < 5; k++) drain_expect(DATA_W'(8'h10 + k));

    // 5. Frame abort after three bits, then an intact word
    spi_cs = 1'b0;
    for (int i = 0; i < 3; i++) begin spi_mosi_in = 1'b1; tick(); end
    idle(1);
    check("t5_ferr", rx_frame_err, 1);
    check("t5_busy", busy, 0);
    check("t5_count", rx_count, 0);
    send_word(8'h5A);
    idle(1);
    check("t5_data", rx_data, 8'h5A);
    drain_expect(8'h5A);
    clear_errors();

    // 6. Asynchronous reset mid-word, between edges
    spi_cs = 1'b0;
    for (int i = 0; i < 4; i++) begin spi_mosi_in = 1'b1; tick(); end
    send_word(8'h33);
    for (int i = 0; i < 4; i++) begin spi_mosi_in = 1'b0; tick(); end
    #2;
    reset = 1'b1;
    #1;
    check("t6_count", rx_count, 0);
    check("t6_valid", rx_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_ferr", rx_frame_err, 0);
    check("t6_data", rx_data, 0);
    model_reset();
    reset = 1'b0;
    send_word(8'h7E);
    idle(1);
    check("t6_word", rx_data, 8'h7E);
    drain_expect(8'h7E);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      spi_cs      = ($urandom_range(0, 15) == 0);
      spi_mosi_in = 1'($urandom);
      rx_ready    = ($urandom_range(0, 3) == 0);
      err_clr     = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
